// File: rtl/psum_accum_drain.sv
// -----------------------------------------------------------------------------
// psum_accum_drain
//
// Purpose:
//   Sits downstream of the corelet output FIFO. During accumulation it pops one
//   row of `col` partial sums per cycle whenever the FIFO has a row available.
//   Over len_kij kernel positions it sums the len_onij output pixels of each pass
//   into a local register-file buffer. It then streams the finished rows, with
//   optional ReLU, to the L1 writeback path over a valid/ready handshake.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   start        in   one-cycle pulse that begins a job (honoured only when idle)
//   relu_en      in   captured at start; 1 clamps negative outputs to zero
//   ofifo_valid  in   OFIFO holds at least one full row
//   ofifo_rd     out  pop strobe to the OFIFO; data_in is consumed in the same cycle
//   data_in      in   OFIFO head row, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//   out_valid    out  out_data/out_addr carry a finished row
//   out_ready    in   downstream accepts the row when out_valid && out_ready
//   out_data     out  accumulated row, with ReLU applied if enabled
//   out_addr     out  output pixel index of out_data
//   busy         out  high whenever a job is in progress (any state but idle)
//   done         out  one-cycle pulse after the last row is accepted
// -----------------------------------------------------------------------------
module psum_accum_drain #(
  parameter int col      = 8,
  parameter int psum_bw  = 16,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int addr_bw  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [addr_bw-1:0]       out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_BW = col * psum_bw;
  localparam int KIJ_BW = (len_kij > 1) ? $clog2(len_kij) : 1;

  localparam logic [KIJ_BW-1:0]  KIJ_LAST  = KIJ_BW'(len_kij - 1);
  localparam logic [addr_bw-1:0] ONIJ_LAST = addr_bw'(len_onij - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [KIJ_BW-1:0]  r_kij_cnt;
  logic [addr_bw-1:0] r_onij_cnt;
  logic [addr_bw-1:0] r_out_cnt;
  logic               r_relu_q;

  // Psum buffer: one row per output pixel. It is never reset; the first
  // kernel position of every job overwrites each row before it is read.
  logic [ROW_BW-1:0]  r_psum_buf [0:len_onij-1];

  logic               w_pop;
  logic               w_out_hs;
  logic               w_acc_last;
  logic               w_out_last;
  logic               w_first_kij;
  logic [ROW_BW-1:0]  w_acc_row;
  logic [ROW_BW-1:0]  w_acc_next;
  logic [ROW_BW-1:0]  w_out_row;
  logic [ROW_BW-1:0]  w_out_relu;

  // ---------------------------------------------------------------------------
  // Handshakes and end-of-phase detection
  // ---------------------------------------------------------------------------
  // The pop is combinational so the FIFO sees the strobe in the same cycle
  // that data_in is consumed. Because r_state clears asynchronously, a reset
  // kills the strobe immediately.
  assign w_pop       = (r_state == S_ACC) && ofifo_valid;
  assign w_out_hs    = (r_state == S_OUT) && out_ready;
  assign w_acc_last  = (r_kij_cnt == KIJ_LAST) && (r_onij_cnt == ONIJ_LAST);
  assign w_out_last  = (r_out_cnt == ONIJ_LAST);
  assign w_first_kij = (r_kij_cnt == '0);

  // Two read ports on the register file: the read-modify-write row and the
  // row being drained. They are never active in the same state.
  assign w_acc_row = r_psum_buf[r_onij_cnt];
  assign w_out_row = r_psum_buf[r_out_cnt];

  // ---------------------------------------------------------------------------
  // Per-column datapath: wrapping accumulate and sign-bit ReLU
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      logic [psum_bw-1:0] w_in_lane;
      logic [psum_bw-1:0] w_buf_lane;
      logic [psum_bw-1:0] w_out_lane;

      assign w_in_lane  = data_in[gi*psum_bw +: psum_bw];
      assign w_buf_lane = w_acc_row[gi*psum_bw +: psum_bw];
      assign w_out_lane = w_out_row[gi*psum_bw +: psum_bw];

      // psum_bw-bit add: overflow wraps modulo 2^psum_bw and never saturates.
      assign w_acc_next[gi*psum_bw +: psum_bw] =
        w_first_kij ? w_in_lane : (w_buf_lane + w_in_lane);

      assign w_out_relu[gi*psum_bw +: psum_bw] =
        (r_relu_q && w_out_lane[psum_bw-1]) ? '0 : w_out_lane;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)                    w_state_next = S_ACC;
      S_ACC:   if (w_pop && w_acc_last)      w_state_next = S_OUT;
      S_OUT:   if (w_out_hs && w_out_last)   w_state_next = S_DONE;
      S_DONE:                                w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and captured mode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_kij_cnt  <= '0;
      r_onij_cnt <= '0;
      r_out_cnt  <= '0;
      r_relu_q   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          // relu_en is captured only here, so later changes during the job
          // have no effect.
          if (start) begin
            r_relu_q   <= relu_en;
            r_kij_cnt  <= '0;
            r_onij_cnt <= '0;
            r_out_cnt  <= '0;
          end
        end
        S_ACC: begin
          // Counters hold through FIFO stalls of any length.
          if (w_pop) begin
            if (r_onij_cnt == ONIJ_LAST) begin
              r_onij_cnt <= '0;
              r_kij_cnt  <= (r_kij_cnt == KIJ_LAST) ? '0 : (r_kij_cnt + 1'b1);
            end else begin
              r_onij_cnt <= r_onij_cnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          // Address and data hold while out_ready is low.
          if (w_out_hs) begin
            r_out_cnt <= w_out_last ? '0 : (r_out_cnt + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer write port. It is clocked only, with no reset, so it can map onto
  // register-file or distributed RAM resources.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_psum_buf[r_onij_cnt] <= w_acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ofifo_rd  = w_pop;
  assign out_valid = (r_state == S_OUT);
  // Gate data so it reads zero outside the drain phase (including reset) and
  // never exposes stale buffer contents.
  assign out_data  = out_valid ? w_out_relu : '0;
  assign out_addr  = r_out_cnt;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
